// File: rtl/au_sub_seq_pkg.sv
// Shared types and helpers for the multi-word sequential subtractor.
package au_sub_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Word-index width; at least one bit so WORDS=1 still has a legal register.
  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/au_sub_mw_seq_slice.sv
// AU_sub_vz: WIDTH-bit prefix subtractor, s = a - b - ci.
// ARCH selects the carry network: 0 serial, 1 Sklansky, 2 Kogge-Stone.
// z reports a == b and ignores ci, so it only means "difference is zero"
// when the borrow-in is clear.
module AU_sub_vz #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             v,
  output logic             z
);

  localparam int LVL = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Subtract as a + ~b + ~ci; fold the carry-in into bit 0's generate.
  logic [WIDTH-1:0] g, p, gt, gp, c;
  logic             c0, cout;

  assign c0 = ~ci;
  assign g  = a & ~b;
  assign p  = ~(a ^ b);
  assign gt = {g[WIDTH-1:1], g[0] | (p[0] & c0)};

  generate
    if (ARCH == 1) begin : g_sklansky
      // Sklansky: each level combines the upper half-block with the top of its lower half.
      always_comb begin
        logic [WIDTH-1:0] gk, pk, gn, pn;
        gk = gt;
        pk = p;
        gn = gt;
        pn = p;
        for (int l = 0; l < LVL; l++) begin
          gn = gk;
          pn = pk;
          for (int i = 0; i < WIDTH; i++) begin
            if (((i >> l) & 1) == 1) begin
              int j;
              j = ((i >> l) << l) - 1;
              gn[i] = gk[i] | (pk[i] & gk[j]);
              pn[i] = pk[i] & pk[j];
            end
          end
          gk = gn;
          pk = pn;
        end
        gp = gk;
      end
    end else if (ARCH == 2) begin : g_kogge
      // Kogge-Stone: every bit combines with the bit 2^l below it each level.
      always_comb begin
        logic [WIDTH-1:0] gk, pk, gn, pn;
        gk = gt;
        pk = p;
        gn = gt;
        pn = p;
        for (int l = 0; l < LVL; l++) begin
          gn = gk;
          pn = pk;
          for (int i = 0; i < WIDTH; i++) begin
            if (i >= (1 << l)) begin
              gn[i] = gk[i] | (pk[i] & gk[i - (1 << l)]);
              pn[i] = pk[i] & pk[i - (1 << l)];
            end
          end
          gk = gn;
          pk = pn;
        end
        gp = gk;
      end
    end else begin : g_serial
      // Serial prefix: one generate/propagate step per bit.
      always_comb begin
        gp = gt;
        for (int i = 1; i < WIDTH; i++)
          gp[i] = gt[i] | (p[i] & gp[i-1]);
      end
    end
  endgenerate

  assign c    = {gp[WIDTH-2:0], c0};
  assign cout = gp[WIDTH-1];
  assign s    = p ^ c;
  assign v    = c[WIDTH-1] ^ cout;
  assign z    = ~|(a ^ b);

endmodule

// File: rtl/au_sub_mw_seq.sv
// au_sub_mw_seq: wide a - b - ci computed one WIDTH-bit word per clock,
// LS word first, through a single AU_sub_vz slice.
// Optional compare flags (lt_u, lt_s) are built when AU_SUB_SEQ_CMP_EN is defined.
module au_sub_mw_seq
  import au_sub_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WORDS = 4,
  parameter int ARCH  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   ci,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH*WORDS-1:0] s,
  output logic                   v,
  output logic                   z
`ifdef AU_SUB_SEQ_CMP_EN
  ,
  output logic                   lt_u,
  output logic                   lt_s
`endif
);

  localparam int IW = idx_w(WORDS);

  state_t                       state;
  logic [IW-1:0]                idx;
  logic [WORDS-1:0][WIDTH-1:0]  a_q, b_q, s_q;
  logic                         borrow, zacc;

  logic [WIDTH-1:0] sl_a, sl_b, sl_s;
  logic             sl_v, sl_z_unused;
  logic             am, bm, sm, nxt_borrow, last, sl_zero;

  // Word mux feeding the shared slice.
  assign sl_a = a_q[idx];
  assign sl_b = b_q[idx];

  AU_sub_vz #(
    .WIDTH (WIDTH),
    .ARCH  (ARCH)
  ) u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (borrow),
    .s  (sl_s),
    .v  (sl_v),
    .z  (sl_z_unused)
  );

  // Borrow-out rebuilt from the MSBs; zero taken from the difference itself
  // because the slice's z ignores its borrow-in.
  assign am         = sl_a[WIDTH-1];
  assign bm         = sl_b[WIDTH-1];
  assign sm         = sl_s[WIDTH-1];
  assign nxt_borrow = (~am & bm) | (~am & sm) | (bm & sm);
  assign sl_zero    = ~|sl_s;
  assign last       = (idx == IW'(WORDS - 1));

  assign s = s_q;

  // Controller FSM: capture on start, step one word per clock, flag on the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      borrow <= 1'b0;
      zacc   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      v      <= 1'b0;
      z      <= 1'b0;
`ifdef AU_SUB_SEQ_CMP_EN
      lt_u   <= 1'b0;
      lt_s   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            borrow <= ci;
            idx    <= '0;
            zacc   <= 1'b1;
            s_q    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          s_q[idx] <= sl_s;
          zacc     <= zacc & sl_zero;
          borrow   <= nxt_borrow;
          idx      <= idx + 1'b1;
          if (last) begin
            v     <= sl_v;
            z     <= zacc & sl_zero;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
`ifdef AU_SUB_SEQ_CMP_EN
            lt_u  <= nxt_borrow;
            lt_s  <= sm ^ sl_v;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_au_sub_mw_seq.sv
// Self-checking bench for au_sub_mw_seq (WIDTH=8, WORDS=4).
module tb_au_sub_mw_seq;

  localparam int W  = 8;
  localparam int WD = 4;
  localparam int N  = W * WD;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         ci = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy, done, v, z;
  logic [N-1:0] s;
`ifdef AU_SUB_SEQ_CMP_EN
  logic         lt_u, lt_s;
`endif

  int tests = 0;
  int fails = 0;

  au_sub_mw_seq #(.WIDTH(W), .WORDS(WD), .ARCH(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .v     (v),
    .z     (z)
`ifdef AU_SUB_SEQ_CMP_EN
    ,
    .lt_u  (lt_u),
    .lt_s  (lt_s)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: plain wide integer arithmetic on the whole operands.
  function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic mci,
                                output logic [31:0] es, output logic ev, output logic ez,
                                output logic elu, output logic els);
    longint sa, sb, sd, ud;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    sd = sa - sb - longint'(mci);
    ud = longint'({32'd0, ma}) - longint'({32'd0, mb}) - longint'(mci);
    es  = ud[31:0];
    ev  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    ez  = (es == 32'd0);
    elu = (ud < 0);
    els = (sd < 0);
  endfunction

  task automatic get_lt(output logic glu, output logic gls);
`ifdef AU_SUB_SEQ_CMP_EN
    glu = lt_u;
    gls = lt_s;
`else
    glu = 1'b0;
    gls = 1'b0;
`endif
  endtask

  // One operation from idle; returns outputs at the done cycle and the latency.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic tci,
                        output logic [31:0] gs, output logic gv, output logic gz,
                        output logic glu, output logic gls, output int lat);
    @(negedge clk);
    a = ta; b = tb; ci = tci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; ci = 1'($urandom);
    lat = 1;
    chk("busy_after_start", busy, 1'b1);
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_low_at_done", busy, 1'b0);
    gs = s; gv = v; gz = z;
    get_lt(glu, gls);
  endtask

  task automatic chk_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                        input logic tci, input logic [31:0] es, input logic ev,
                        input logic ez, input logic elu, input logic els);
    logic [31:0] gs;
    logic gv, gz, glu, gls;
    int lat;
    run_op(ta, tb, tci, gs, gv, gz, glu, gls, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(WD + 1));
    chk({tag, "_s"}, gs, es);
    chk({tag, "_v"}, gv, ev);
    chk({tag, "_z"}, gz, ez);
`ifdef AU_SUB_SEQ_CMP_EN
    chk({tag, "_lt_u"}, glu, elu);
    chk({tag, "_lt_s"}, gls, els);
`else
    if (glu || gls) chk({tag, "_lt_absent"}, {glu, gls}, 2'b00);
`endif
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        ci;
    logic [31:0] s;
    logic        v, z, lu, ls;
  } vec_t;

  initial begin
    vec_t tbl[5];
    logic [31:0] es, ra, rb;
    logic ev, ez, elu, els, rci, seen;
    int lat;

    tbl[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_s", s, 32'd0);
    chk("rst_v", v, 1'b0);
    chk("rst_z", z, 1'b0);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 5; i++)
      chk_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].ci,
             tbl[i].s, tbl[i].v, tbl[i].z, tbl[i].lu, tbl[i].ls);

    // Randomised against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      ra  = $urandom;
      rb  = (i % 5 == 0) ? ra : $urandom;
      if (i % 7 == 3) rb = {ra[31:8], 8'($urandom)};
      rci = 1'($urandom);
      model(ra, rb, rci, es, ev, ez, elu, els);
      chk_op($sformatf("rnd%0d", i), ra, rb, rci, es, ev, ez, elu, els);
    end

    // start pulses while busy are ignored
    @(negedge clk);
    a = 32'h1122_3344; b = 32'h0102_0304; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    lat = 1;
    start = 1'b0;
    while (!done && lat < 20) begin
      start = (lat == 2 || lat == 3);
      a = 32'hFFFF_FFFF; b = 32'h0; ci = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk("ign_lat", 64'(lat), 64'(WD + 1));
    chk("ign_s", s, 32'h1020_3040);
    chk("ign_z", z, 1'b0);

    // start in the done cycle is accepted
    a = 32'h0000_0100; b = 32'h0000_0001; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", busy, 1'b1);
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_lat", 64'(lat), 64'(WD + 1));
    chk("b2b_s", s, 32'h0000_00FF);

    // result holds after done
    repeat (3) @(negedge clk);
    chk("hold_s", s, 32'h0000_00FF);
    chk("hold_done", done, 1'b0);

    // reset mid-run aborts with every output back to zero
    chk_op("pre_rst", 32'h8000_0000, 32'h0000_0001, 1'b0,
           32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    a = 32'h0; b = 32'h1; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_s", s, 32'd0);
    chk("abort_v", v, 1'b0);
    chk("abort_z", z, 1'b0);
`ifdef AU_SUB_SEQ_CMP_EN
    chk("abort_lt_s", lt_s, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("abort_no_done", seen, 1'b0);

    // normal operation after the abort
    chk_op("post_rst", 32'h0000_0005, 32'h0000_0003, 1'b0,
           32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/au_sub_mw_seq.md
# au_sub_mw_seq

Multi-word sequential subtractor controller. It computes a wide two's-complement difference `a - b - ci` of `WIDTH*WORDS` bits by stepping one `WIDTH`-bit `AU_sub_vz` slice over the operand, least-significant word first, one word per clock. It chains the borrow between words and accumulates the zero and overflow flags. It sits in the arithmetic unit wherever a wide subtract/compare is needed but a full-width prefix subtractor costs too much area.

## Interface
Parameters:
- `WIDTH`, 8, slice word length (>= 2)
- `WORDS`, 4, number of slices (>= 1); total operand width is `WIDTH*WORDS`
- `ARCH`, 0, prefix architecture passed to the slice subtractor (0 to 2)

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `start`  in  1  request; sampled only when `busy`=0
- `a`  in  `WIDTH*WORDS`  minuend; sampled with accepted `start`
- `b`  in  `WIDTH*WORDS`  subtrahend; sampled with accepted `start`
- `ci`  in  1  borrow-in (subtracted); sampled with accepted `start`
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle result-valid pulse
- `s`  out  `WIDTH*WORDS`  difference
- `v`  out  1  two's-complement overflow of the full-width result
- `z`  out  1  full-width difference is zero

## Operation
- FSM has two states, IDLE and RUN. Registers: operand copies, word index `idx` (`$clog2(WORDS)` bits, min 1), borrow, zero accumulator, result.
- IDLE with `start`=1: capture `a`, `b` and `ci`; set borrow = `ci`, `idx`=0 and zero-acc=1; clear `s`; go to RUN.
- RUN, each edge:
  - Slice inputs: word `idx` of `a` and `b`, with slice `ci` = borrow.
  - Write the slice difference into word `idx` of `s`.
  - zero-acc &= (slice difference == 0). Use the reduction of the slice difference, not the slice `z` output, because that output is invalid for a nonzero borrow-in.
  - Next borrow = `(~a_m & b_m) | (~a_m & s_m) | (b_m & s_m)`, from the slice MSBs (`m` = bit `WIDTH-1`).
  - `idx` increments.
- On the edge that processes `idx == WORDS-1`:
  - `v` = slice `v`.
  - `z` = final zero-acc.
  - Pulse `done`.
  - Return to IDLE.
- `start` while `busy`=1 is ignored; there is no queueing.
- `s`, `v` and `z` hold their values from `done` until the next accepted `start`. During RUN, `s` is partially written and must not be checked.

## Timing
- Reset values: IDLE, `busy`=0, `done`=0, `s`=0, `v`=0, `z`=0, and the flags below =0.
- If `start` is accepted in cycle 0:
  - `busy`=1 in cycles 1..WORDS.
  - `done`=1 and `busy`=0 in cycle WORDS+1.
  - Latency is WORDS+1 cycles start-to-done.
- `WORDS`=1: `busy` for one cycle, `done` in cycle 2.
- `start` in the `done` cycle is accepted, so back-to-back throughput is one result per WORDS+1 cycles.
- Reset asserted mid-RUN aborts immediately. No `done` is produced, and every output returns to its reset value.
- Inputs `a`, `b` and `ci` are don't-care outside the accepting cycle.
- The slice path is combinational from registered operands to the result registers. The critical path is one `WIDTH`-bit prefix subtract plus borrow logic.

## Configuration
- `AU_SUB_SEQ_CMP_EN` defined:
  - Adds output ports `lt_u` (1, unsigned `a < b + ci`, equal to the final borrow-out) and `lt_s` (1, signed less-than, equal to `s[MSB] ^ v`).
  - Both are registered with `done`, hold like `v`, and reset to 0.
- Undefined: these ports and the final-borrow capture register are absent; the rest of the behaviour is identical.

## Structure
- Package `au_sub_seq_pkg`: state enum (IDLE, RUN) and an index-width function.
- One sub-module: an existing `AU_sub_vz` instance with `WIDTH=WIDTH` and `ARCH=ARCH`, used as the slice datapath.
- The controller contains the FSM, the word mux, borrow derivation and flag accumulation.

## Test plan
All scenarios use WIDTH=8 and WORDS=4.
- `a`=0x00000005, `b`=0x00000003, `ci`=0 -> `s`=0x00000002, `v`=0, `z`=0, `done` in cycle 5.
- `a`=`b`=0x12345678, `ci`=0 -> `s`=0, `z`=1, `v`=0.
- `a`=0, `b`=1 -> borrow ripples through all words, `s`=0xFFFFFFFF, `v`=0, `z`=0, `lt_u`=1, `lt_s`=1.
- `a`=0x80000000, `b`=1 -> `s`=0x7FFFFFFF, `v`=1, `lt_s`=1, `lt_u`=0.
- `a`=5, `b`=5, `ci`=1 -> `s`=0xFFFFFFFF, `z`=0. This confirms that zero is taken from the result, not from the slice `z` output.
- Control sequence:
  - `start` pulses while `busy` -> ignored, and the result matches the first operands.
  - `start` in the `done` cycle -> accepted.
  - `rst_n` low in cycle 2 of a run -> `busy`=0, no `done`, all outputs 0.
